// File: rtl/bypass_buffer_arbiter_if.sv
// bypass_buffer_arbiter_if: write-requester and consumer signals of the
// bypass buffer arbiter. master = requesters + consumer, slave = arbiter.
interface bypass_buffer_arbiter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SOURCES = 4
);
  localparam int unsigned SOURCE_INDEX_WIDTH = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  logic [SOURCES-1:0]            write_request;
  logic [SOURCES*WIDTH-1:0]      write_data;
  logic [SOURCES-1:0]            write_grant;
  logic                          read_enable;
  logic [WIDTH-1:0]              read_data;
  logic [SOURCE_INDEX_WIDTH-1:0] read_source;
  logic                          full;
  logic                          empty;

  modport master (
    output write_request, write_data, read_enable,
    input  write_grant, read_data, read_source, full, empty
  );

  modport slave (
    input  write_request, write_data, read_enable,
    output write_grant, read_data, read_source, full, empty
  );
endinterface

// File: rtl/bypass_buffer_arbiter.sv
// bypass_buffer_arbiter: single-entry bypass buffer shared by SOURCES
// requesters. Granted data goes straight to the reader in the same cycle
// or is parked in the entry until popped.
// Build option BYPASS_BUFFER_ARBITER_ROUND_ROBIN_EN: when defined, the
// arbiter rotates priority with a pointer; otherwise the lowest requesting
// index always wins and no pointer register exists.
module bypass_buffer_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SOURCES = 4
) (
  input logic                    clock,
  input logic                    reset,
  bypass_buffer_arbiter_if.slave bus
);
  localparam int unsigned SOURCE_INDEX_WIDTH = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  logic [WIDTH-1:0]              data_q;
  logic [SOURCE_INDEX_WIDTH-1:0] source_q;
  logic                          full_q;

  logic                          any_request;
  logic                          accept;
  logic                          store_en;
  logic                          found;
  logic [SOURCE_INDEX_WIDTH-1:0] winner;
  logic [WIDTH-1:0]              winner_data;

  assign any_request = |bus.write_request;
  assign accept      = any_request && (!full_q || bus.read_enable);
  // Parking is needed unless an empty entry is bypassed straight to the reader.
  assign store_en    = accept && (full_q || !bus.read_enable);

`ifdef BYPASS_BUFFER_ARBITER_ROUND_ROBIN_EN
  logic [SOURCE_INDEX_WIDTH-1:0] priority_index;
  int unsigned                   idx;

  // Round-robin pick: first requester at or after the pointer, with wrap.
  always_comb begin
    winner      = '0;
    winner_data = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < SOURCES; k++) begin
      idx = 32'(priority_index) + k;
      if (idx >= SOURCES) begin
        idx = idx - SOURCES;
      end
      if (!found && bus.write_request[SOURCE_INDEX_WIDTH'(idx)]) begin
        found       = 1'b1;
        winner      = SOURCE_INDEX_WIDTH'(idx);
        winner_data = bus.write_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves just past the winner on every accepted grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      priority_index <= '0;
    end else if (accept) begin
      if (winner == SOURCE_INDEX_WIDTH'(SOURCES - 1)) begin
        priority_index <= '0;
      end else begin
        priority_index <= winner + SOURCE_INDEX_WIDTH'(1);
      end
    end
  end
`else
  // Fixed-priority pick: lowest requesting index wins.
  always_comb begin
    winner      = '0;
    winner_data = '0;
    found       = 1'b0;
    for (int unsigned k = 0; k < SOURCES; k++) begin
      if (!found && bus.write_request[SOURCE_INDEX_WIDTH'(k)]) begin
        found       = 1'b1;
        winner      = SOURCE_INDEX_WIDTH'(k);
        winner_data = bus.write_data[k*WIDTH +: WIDTH];
      end
    end
  end
`endif

  // One-hot grant to the winner whenever the entry can take data.
  always_comb begin
    bus.write_grant = '0;
    if (!reset && accept) begin
      bus.write_grant[winner] = 1'b1;
    end
  end

  // Head of the buffer: parked entry first, else bypass of the current winner.
  always_comb begin
    bus.read_data   = '0;
    bus.read_source = '0;
    if (!reset) begin
      if (full_q) begin
        bus.read_data   = data_q;
        bus.read_source = source_q;
      end else if (any_request) begin
        bus.read_data   = winner_data;
        bus.read_source = winner;
      end
    end
  end

  assign bus.full  = full_q;
  assign bus.empty = !full_q && !any_request;

  // Entry register: park the winner, or release the entry on a read with no refill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q   <= 1'b0;
      data_q   <= '0;
      source_q <= '0;
    end else if (store_en) begin
      full_q   <= 1'b1;
      data_q   <= winner_data;
      source_q <= winner;
    end else if (full_q && bus.read_enable) begin
      full_q   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bypass_buffer_arbiter.sv
// tb_bypass_buffer_arbiter: vector table for the directed cases, then a
// scoreboard-driven model for fairness, reset and random traffic.
module tb_bypass_buffer_arbiter;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SOURCES = 4;

  logic clock = 1'b0;
  logic reset;

  bypass_buffer_arbiter_if #(.WIDTH(WIDTH), .SOURCES(SOURCES)) bus ();

  bypass_buffer_arbiter #(.WIDTH(WIDTH), .SOURCES(SOURCES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        ren;
    logic [3:0]  grant;
    logic [7:0]  rdata;
    logic [1:0]  rsrc;
    logic        full;
    logic        empty;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] src;
  } entry_t;

  int     errors = 0;
  int     checks = 0;
  entry_t sb_q[$];
  int     rr_ptr = 0;
  int     pops = 0;
  bit     last_acc;
  int     last_w;
  int     gcount[4];
  vec_t   vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int ptr);
    int idx;
`ifdef BYPASS_BUFFER_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (req[idx]) return idx;
    end
`else
    idx = ptr;
    for (int k = 0; k < 4; k++) begin
      if (req[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.write_request = '0;
    bus.write_data    = '0;
    bus.read_enable   = 1'b0;
    #2;
    check("reset_grant", 32'(bus.write_grant), 32'h0);
    check("reset_rdata", 32'(bus.read_data), 32'h0);
    check("reset_full",  32'(bus.full), 32'h0);
    check("reset_empty", 32'(bus.empty), 32'h1);
    @(negedge clock);
    reset  = 1'b0;
    sb_q.delete();
    rr_ptr = 0;
  endtask

  // One cycle against the reference model; scoreboard pushes on accept, pops on read.
  task automatic model_cycle(input logic [3:0] req, input logic [31:0] data, input logic ren);
    int         w;
    bit         full_m, empty_m, acc, popped;
    logic [3:0] exp_grant;
    entry_t     e, head;
    @(negedge clock);
    bus.write_request = req;
    bus.write_data    = data;
    bus.read_enable   = ren;
    #2;
    full_m  = (sb_q.size() != 0);
    empty_m = !full_m && (req == 4'b0);
    w       = pick(req, rr_ptr);
    acc     = (req != 4'b0) && (!full_m || ren);
    exp_grant = '0;
    if (acc) exp_grant[w] = 1'b1;
    check("m_grant",   32'(bus.write_grant), 32'(exp_grant));
    check("m_onehot0", 32'($onehot0(bus.write_grant)), 32'h1);
    check("m_full",    32'(bus.full), 32'(full_m));
    check("m_empty",   32'(bus.empty), 32'(empty_m));
    for (int i = 0; i < 4; i++) if (bus.write_grant[i]) gcount[i]++;
    popped = 1'b0;
    if (full_m && ren) begin
      e = sb_q.pop_front();
      check("sb_data", 32'(bus.read_data), 32'(e.data));
      check("sb_src",  32'(bus.read_source), 32'(e.src));
      popped = 1'b1;
      pops++;
    end
    if (acc) begin
      e.data = data[w*8 +: 8];
      e.src  = 2'(w);
      sb_q.push_back(e);
      rr_ptr = (w == 3) ? 0 : w + 1;
    end
    if (!full_m && ren && acc) begin
      e = sb_q.pop_front();
      check("sb_data", 32'(bus.read_data), 32'(e.data));
      check("sb_src",  32'(bus.read_source), 32'(e.src));
      popped = 1'b1;
      pops++;
    end
    if (!popped) begin
      if (sb_q.size() != 0) begin
        head = sb_q[0];
        check("head_data", 32'(bus.read_data), 32'(head.data));
        check("head_src",  32'(bus.read_source), 32'(head.src));
      end else begin
        check("head_data", 32'(bus.read_data), 32'h0);
        check("head_src",  32'(bus.read_source), 32'h0);
      end
    end
    last_acc = acc;
    last_w   = w;
  endtask

  initial begin
    logic [3:0]  pend;
    logic [31:0] pdata;
    int          cyc;

    //          req      data          ren   grant    rdata  rsrc full empty
    vecs[0]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b1};
    vecs[1]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b1};
    vecs[3]  = '{4'b0010, 32'h00003C00, 1'b0, 4'b0010, 8'h3C, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 32'h00003C00, 1'b0, 4'b0000, 8'h3C, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h3C, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b1};
    vecs[7]  = '{4'b0001, 32'h00000011, 1'b0, 4'b0001, 8'h11, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{4'b1000, 32'h22000000, 1'b1, 4'b1000, 8'h11, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h22, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h22, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b1};
    vecs[12] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b1};
    vecs[13] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b1};
    vecs[14] = '{4'b1010, 32'h77005500, 1'b0, 4'b0010, 8'h55, 2'd1, 1'b0, 1'b0};
    vecs[15] = '{4'b1000, 32'h77000000, 1'b1, 4'b1000, 8'h55, 2'd1, 1'b1, 1'b0};
    vecs[16] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 8'h77, 2'd3, 1'b1, 1'b0};
    vecs[17] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b1};

    reset = 1'b1;
    bus.write_request = '0;
    bus.write_data    = '0;
    bus.read_enable   = 1'b0;

    // Directed vector table
    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      bus.write_request = vecs[i].req;
      bus.write_data    = vecs[i].data;
      bus.read_enable   = vecs[i].ren;
      #2;
      check($sformatf("vec%0d_grant", i), 32'(bus.write_grant), 32'(vecs[i].grant));
      check($sformatf("vec%0d_rdata", i), 32'(bus.read_data),   32'(vecs[i].rdata));
      check($sformatf("vec%0d_rsrc", i),  32'(bus.read_source), 32'(vecs[i].rsrc));
      check($sformatf("vec%0d_full", i),  32'(bus.full),        32'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 32'(bus.empty),       32'(vecs[i].empty));
    end

    // Fairness with all sources requesting and the consumer always reading
    do_reset();
    for (int i = 0; i < 4; i++) gcount[i] = 0;
    for (int i = 0; i < 100; i++) model_cycle(4'b1111, 32'h13121110, 1'b1);
`ifdef BYPASS_BUFFER_ARBITER_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) check($sformatf("fair_count%0d", i), 32'(gcount[i]), 32'd25);
`else
    check("fixed_count0", 32'(gcount[0]), 32'd100);
    for (int i = 1; i < 4; i++) check($sformatf("fixed_count%0d", i), 32'(gcount[i]), 32'd0);
`endif

    // Reset asserted while the entry is full and the pointer sits at 2
    do_reset();
    model_cycle(4'b0010, 32'h00003C00, 1'b0);
    model_cycle(4'b1010, 32'h44003C00, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_full",  32'(bus.full), 32'h0);
    check("rst_mid_rdata", 32'(bus.read_data), 32'h0);
    check("rst_mid_rsrc",  32'(bus.read_source), 32'h0);
    check("rst_mid_grant", 32'(bus.write_grant), 32'h0);
    check("rst_mid_empty", 32'(bus.empty), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    bus.write_request = '0;
    bus.read_enable   = 1'b0;
    sb_q.delete();
    rr_ptr = 0;
    model_cycle(4'b1010, 32'h44003C00, 1'b1);
    check("rst_release_grant", 32'(bus.write_grant), 32'h2);

    // Random traffic: held requests, reads at one-in-two
    do_reset();
    pend  = '0;
    pdata = '0;
    pops  = 0;
    cyc   = 0;
    while (pops < 100 && cyc < 1000) begin
      for (int s = 0; s < 4; s++) begin
        if (!pend[s] && $urandom_range(1, 0) == 1) begin
          pend[s] = 1'b1;
          pdata[s*8 +: 8] = 8'($urandom);
        end
      end
      model_cycle(pend, pdata, 1'($urandom_range(1, 0)));
      if (last_acc) pend[last_w] = 1'b0;
      cyc++;
    end
    check("random_transfers", 32'(pops), 32'd100);
    for (int i = 0; i < 3; i++) model_cycle(4'b0000, 32'h0, 1'b1);
    @(negedge clock);
    bus.read_enable = 1'b0;
    #2;
    check("final_empty", 32'(bus.empty), 32'h1);
    check("final_full",  32'(bus.full), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bypass_buffer_arbiter.md
# bypass_buffer_arbiter

Shares a single-entry bypass buffer between `SOURCES` write requesters using round-robin arbitration. Requesters present data and a request; the arbiter grants one per cycle. The granted data either passes straight to the read side in the same cycle (bypass) or is stored in the single entry. It sits in front of a single downstream consumer that uses the access-enable read protocol of the bypass buffer family.

## Interface
- `WIDTH`, 8, data width in bits.
- `SOURCES`, 4, number of write requesters (≥2).
- `SOURCE_INDEX_WIDTH`, `$clog2(SOURCES)`, width of the source tag (derived, not overridden).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `write_request`  in  `SOURCES`  per-source request; held with data until granted.
- `write_data`  in  `SOURCES*WIDTH`  packed per-source data; source i occupies bits `[i*WIDTH +: WIDTH]`.
- `write_grant`  out  `SOURCES`  one-hot; high in the cycle the source's data is accepted.
- `read_enable`  in  1  consumer pops the current entry.
- `read_data`  out  `WIDTH`  data at the head.
- `read_source`  out  `SOURCE_INDEX_WIDTH`  index of the source that produced `read_data`.
- `full`  out  1  entry occupied.
- `empty`  out  1  nothing to read: entry free and no request pending.

## Operation
- State is one data register, one source-tag register, the `full` flag and the round-robin pointer `priority_index`.
- Acceptance condition: `accept = any(write_request) && (!full || read_enable)`.
- Arbitration: the winner is the first requesting source at or after `priority_index`, searching upward with wrap from `SOURCES-1` to 0.
  - `write_grant[winner] = accept`. All other grants are 0. Grants are combinational from requests, `full` and `read_enable`.
- Pointer update on an accepted grant: `priority_index <= (winner == SOURCES-1) ? 0 : winner+1`. It is unchanged otherwise.
- Read side:
  - When `full`, `read_data` and `read_source` come from the registers.
  - When not full and a request exists, they show the current winner's data and index combinationally (bypass).
  - When `empty`, both are 0.
- `empty = !full && !any(write_request)`.
- Next state of `full`:
  - Not full, grant, `read_enable`: the bypass transfer completes; `full` stays 0 and nothing is stored.
  - Not full, grant, no read: store the winner's data and tag; `full <= 1`.
  - Full, `read_enable`, grant: the registers take the winner's data and tag; `full` stays 1.
  - Full, `read_enable`, no request: `full <= 0`.
  - Full, no read: hold; `write_grant` is all 0.
- Illegal usage:
  - `read_enable` while `empty` is ignored and has no state change.
  - Dropping a request before it is granted is allowed; the data is simply not taken.

## Timing
- Reset values while `reset` is high, applied asynchronously: `full=0`, `priority_index=0`, data/tag registers 0, `write_grant=0`, `read_data=0`, `read_source=0`. `empty` follows its equation, so it is 1 when no requests are present.
- Latency:
  - Bypass transfer: 0 cycles (write granted and read in the same cycle).
  - Stored transfer: data is readable from the cycle after the grant.
- Throughput: one transfer per cycle, sustained, both when empty-with-bypass and when full with simultaneous read.
- Fairness: with all sources continuously requesting, each source is granted exactly once every `SOURCES` accepted transfers.
- Reset released mid-operation: the first grant after release goes to the lowest-index requester.

## Configuration
- Macro `BYPASS_BUFFER_ARBITER_ROUND_ROBIN_EN`.
  - Defined: round-robin arbitration with `priority_index` as described.
  - Undefined: fixed priority, where the lowest requesting index always wins. `priority_index` is not implemented and no pointer register is inferred.
- All other behaviour is identical in both builds.

## Test plan
Setup for all scenarios: `WIDTH=8`, `SOURCES=4`.

- Bypass: after reset, source 2 requests `0xA5` with `read_enable=1` in the same cycle.
  - Same cycle: `write_grant=0100`, `read_data=0xA5`, `read_source=2`, `empty=0`, `full=0`.
  - Next cycle: `empty=1`, `full=0`.
- Store then read: source 1 writes `0x3C` with no read.
  - Next cycle: `full=1`, `read_data=0x3C`, `read_source=1`, `write_grant=0` while sources keep requesting.
  - After `read_enable` for one cycle: `full=0`, `empty=1`.
- Full with simultaneous read/write: entry holds `0x11` from source 0; source 3 requests `0x22` and the consumer reads.
  - Read returns `0x11`; `write_grant=1000`.
  - Next cycle: `read_data=0x22`, `read_source=3`, `full=1`.
- Round-robin fairness: all 4 sources request continuously with distinct data and `read_enable=1` for 100 cycles.
  - Grant order is 0,1,2,3,0,… and each source is granted 25 times.
  - Without the macro, source 0 is granted all 100 times.
- Reset mid-operation: assert `reset` while `full=1` and `priority_index=2`.
  - Immediately: `full=0`, `read_data=0`, `write_grant=0`.
  - After release with sources 1 and 3 requesting: grant goes to source 1.
- Random: 100 transfers with requests and reads each at probability 0.5 and a 1000-cycle timeout.
  - Every read matches the scoreboarded data/source pair.
  - `write_grant` is always one-hot or zero.
  - The bench ends with `empty=1` and `full=0`.
